// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control tokens, symbol decode helpers and alignment FSM states
package tmds_pkg;
  localparam logic [9:0] TOK_CTRL0 = 10'h354;
  localparam logic [9:0] TOK_CTRL1 = 10'h0AB;
  localparam logic [9:0] TOK_CTRL2 = 10'h154;
  localparam logic [9:0] TOK_CTRL3 = 10'h2AB;
  typedef enum logic [1:0] {SEARCH, SLIP, WAIT, LOCKED} state_t;
  function automatic logic is_token(input logic [9:0] w);
    return w == TOK_CTRL0 || w == TOK_CTRL1 || w == TOK_CTRL2 || w == TOK_CTRL3;
  endfunction
  function automatic logic [1:0] ctrl_from_token(input logic [9:0] w);
    return w == TOK_CTRL1 ? 2'b01 : w == TOK_CTRL2 ? 2'b10 : w == TOK_CTRL3 ? 2'b11 : 2'b00;
  endfunction
  function automatic logic [7:0] tmds_decode_8b(input logic [9:0] w);
    logic [7:0] q;
    q = w[9] ? ~w[7:0] : w[7:0];
    return {q[7:1] ^ q[6:0] ^ {7{~w[8]}}, q[0]};
  endfunction
endpackage

// File: rtl/tmds_align_fsm.sv
// tmds_align_fsm: symbol alignment search, bitslip control and lock tracking
module tmds_align_fsm
  import tmds_pkg::*;
#(
  parameter int CTRL_TOKEN_MIN = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_WAIT      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       is_token,
  output logic       bitslip,
  output logic       aligned,
  output logic [3:0] slip_count
);
  localparam int RW = $clog2(CTRL_TOKEN_MIN + 1);
  localparam int GW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int WW = $clog2(SLIP_WAIT + 1);
  state_t state_q, state_d;
  logic [RW-1:0] run_q, run_d, run_inc;
  logic [GW-1:0] gap_q, gap_d, gap_inc;
  logic [WW-1:0] wait_q, wait_d;
  logic [3:0] slip_q, slip_d;
  logic bitslip_q, bitslip_d, aligned_q, aligned_d;
  always_comb begin
    run_inc = is_token ? run_q + 1'b1 : '0;
    gap_inc = is_token ? '0 : gap_q + 1'b1;
    state_d = state_q;
    run_d = '0;
    gap_d = '0;
    wait_d = '0;
    case (state_q)
      SEARCH: begin
        run_d = run_inc;
        gap_d = gap_inc;
        state_d = run_inc >= RW'(CTRL_TOKEN_MIN) ? LOCKED : gap_inc >= GW'(SEARCH_TIMEOUT) ? SLIP : SEARCH;
      end
      SLIP: state_d = WAIT;
      WAIT: begin
        wait_d = wait_q + 1'b1;
        state_d = wait_q == WW'(SLIP_WAIT - 1) ? SEARCH : WAIT;
      end
      LOCKED: begin
        gap_d = gap_inc;
        state_d = gap_inc >= GW'(SEARCH_TIMEOUT) ? SEARCH : LOCKED;
      end
      default: state_d = SEARCH;
    endcase
    if (state_d != state_q) begin
      run_d = '0;
      gap_d = '0;
      wait_d = '0;
    end
    slip_d = state_d == SLIP ? (slip_q == 4'd9 ? 4'd0 : slip_q + 1'b1) :
             (state_q == LOCKED && state_d == SEARCH) ? 4'd0 : slip_q;
    bitslip_d = state_d == SLIP;
    aligned_d = state_d == LOCKED;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEARCH;
      run_q <= '0;
      gap_q <= '0;
      wait_q <= '0;
      slip_q <= '0;
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q <= run_d;
      gap_q <= gap_d;
      wait_q <= wait_d;
      slip_q <= slip_d;
      bitslip_q <= bitslip_d;
      aligned_q <= aligned_d;
    end
  end
  assign bitslip = bitslip_q;
  assign aligned = aligned_q;
  assign slip_count = slip_q;
endmodule

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: per-channel DVI receive back end with alignment and TMDS decode
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_TOKEN_MIN = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int SLIP_WAIT      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] rx_word,
  output logic       bitslip,
  output logic       aligned,
  output logic       de,
  output logic [1:0] ctrl,
  output logic [7:0] data,
  output logic [3:0] slip_count
);
  logic [9:0] word_q;
  logic tok_q, tok_d;
  logic de_q, de_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic [7:0] data_q, data_d;
  tmds_align_fsm #(
    .CTRL_TOKEN_MIN(CTRL_TOKEN_MIN),
    .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
    .SLIP_WAIT(SLIP_WAIT)
  ) u_fsm (
    .clk(clk),
    .rst(rst),
    .is_token(tok_q),
    .bitslip(bitslip),
    .aligned(aligned),
    .slip_count(slip_count)
  );
  always_comb begin
    tok_d = is_token(rx_word);
    de_d = aligned & ~tok_q;
    ctrl_d = aligned & tok_q ? ctrl_from_token(word_q) : ctrl_q;
    data_d = !aligned ? 8'h00 : tok_q ? data_q : tmds_decode_8b(word_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      tok_q <= 1'b0;
      de_q <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      word_q <= rx_word;
      tok_q <= tok_d;
      de_q <= de_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end
  assign de = de_q;
  assign ctrl = ctrl_q;
  assign data = data_q;
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: table, scoreboard and sequence checks of the TMDS channel decoder
module tb_tmds_channel_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [9:0] rx_word = '0;
  logic bitslip, aligned, de;
  logic [1:0] ctrl;
  logic [7:0] data;
  logic [3:0] slip_count;
  int total = 0;
  int bad = 0;
  int slips = 0;
  logic prev_slip = 1'b0;
  logic [1:0] m_ctrl = '0;
  logic [7:0] m_data = '0;
  typedef struct {logic chk; logic de; logic [1:0] ctrl; logic [7:0] data;} exp_t;
  typedef struct {logic [9:0] w; logic de; logic [1:0] ctrl; logic [7:0] data;} vec_t;
  exp_t exp_q[$];
  vec_t vt[11];
  tmds_channel_decoder dut (
    .clk(clk),
    .rst(rst),
    .rx_word(rx_word),
    .bitslip(bitslip),
    .aligned(aligned),
    .de(de),
    .ctrl(ctrl),
    .data(data),
    .slip_count(slip_count)
  );
  always #5 clk = ~clk;
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask
  function automatic logic [7:0] ref_dec(input logic [9:0] w);
    logic [7:0] q, d;
    for (int i = 0; i < 8; i++) q[i] = w[i] ^ w[9];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = w[8] ? q[i] ^ q[i-1] : ~(q[i] ^ q[i-1]);
    return d;
  endfunction
  function automatic int ref_tok(input logic [9:0] w);
    case (w)
      10'h354: return 0;
      10'h0AB: return 1;
      10'h154: return 2;
      10'h2AB: return 3;
      default: return -1;
    endcase
  endfunction
  function automatic logic [9:0] rot(input logic [9:0] t, input int off);
    logic [19:0] x;
    x = {t, t} >> off;
    return x[9:0];
  endfunction
  task automatic expect_word(input logic [9:0] w, input logic lk);
    exp_t e;
    int t;
    t = ref_tok(w);
    if (!lk) m_data = 8'h00;
    else if (t >= 0) m_ctrl = t[1:0];
    else m_data = ref_dec(w);
    e = '{1'b1, lk && t < 0, m_ctrl, m_data};
    exp_q.push_back(e);
  endtask
  task automatic send(input logic [9:0] w);
    exp_t e;
    rx_word = w;
    @(posedge clk);
    #1;
    if (bitslip) begin
      slips++;
      chk("bitslip_consecutive", {31'd0, prev_slip}, 32'd0);
    end
    prev_slip = bitslip;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        chk("sb_de", {31'd0, de}, {31'd0, e.de});
        chk("sb_ctrl", {30'd0, ctrl}, {30'd0, e.ctrl});
        chk("sb_data", {24'd0, data}, {24'd0, e.data});
      end
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    rx_word = '0;
    exp_q.delete();
    m_ctrl = '0;
    m_data = '0;
    prev_slip = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_bitslip"}, {31'd0, bitslip}, 32'd0);
    chk({tag, "_aligned"}, {31'd0, aligned}, 32'd0);
    chk({tag, "_de"}, {31'd0, de}, 32'd0);
    chk({tag, "_ctrl"}, {30'd0, ctrl}, 32'd0);
    chk({tag, "_data"}, {24'd0, data}, 32'd0);
    chk({tag, "_slip_count"}, {28'd0, slip_count}, 32'd0);
  endtask
  initial begin
    int s0, ns, s3, off;
    exp_t e;
    vt[0]  = '{10'h100, 1'b1, 2'd0, 8'h00};
    vt[1]  = '{10'h0AB, 1'b0, 2'd1, 8'h00};
    vt[2]  = '{10'h1FF, 1'b1, 2'd1, 8'h01};
    vt[3]  = '{10'h2AB, 1'b0, 2'd3, 8'h01};
    vt[4]  = '{10'h0FF, 1'b1, 2'd3, 8'hFF};
    vt[5]  = '{10'h154, 1'b0, 2'd2, 8'hFF};
    vt[6]  = '{10'h000, 1'b1, 2'd2, 8'hFE};
    vt[7]  = '{10'h10F, 1'b1, 2'd2, 8'h11};
    vt[8]  = '{10'h354, 1'b0, 2'd0, 8'h11};
    vt[9]  = '{10'h155, 1'b1, 2'd0, 8'hFF};
    vt[10] = '{10'h2FF, 1'b1, 2'd0, 8'hFE};
    do_reset();
    check_reset("reset");
    s0 = slips;
    for (int i = 1; i <= 20; i++) begin
      expect_word(10'h354, i >= 9);
      send(10'h354);
      chk("t1_aligned", {31'd0, aligned}, {31'd0, i >= 9});
    end
    chk("t1_no_slip", slips, s0);
    for (int i = 0; i < 11; i++) begin
      e = '{1'b1, vt[i].de, vt[i].ctrl, vt[i].data};
      exp_q.push_back(e);
      send(vt[i].w);
    end
    m_ctrl = 2'd0;
    m_data = 8'hFE;
    for (int w = 0; w < 1024; w++) begin
      expect_word(10'(w), 1'b1);
      send(10'(w));
    end
    chk("t3_aligned", {31'd0, aligned}, 32'd1);
    s0 = slips;
    expect_word(10'h354, 1'b1);
    send(10'h354);
    for (int i = 1; i <= 4100; i++) begin
      expect_word(10'h100, i <= 4096);
      send(10'h100);
      if (i >= 4095) chk("t5_aligned", {31'd0, aligned}, {31'd0, i <= 4096});
    end
    chk("t5_no_slip", slips, s0);
    chk("t5_slip_count", {28'd0, slip_count}, 32'd0);
    do_reset();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        send(i < 7 ? 10'h354 : 10'h100);
        chk("t4_no_lock", {31'd0, aligned}, 32'd0);
      end
    end
    for (int i = 1; i <= 9; i++) begin
      send(10'h354);
      chk("t4_lock", {31'd0, aligned}, {31'd0, i == 9});
    end
    do_reset();
    off = 3;
    ns = 0;
    s3 = 0;
    for (int n = 1; n <= 12360; n++) begin
      send(rot(10'h354, off));
      if (bitslip) begin
        ns++;
        chk("t2_slip_pos", n, 4096 + 4113 * (ns - 1));
        off = (off + 9) % 10;
        if (ns == 3) s3 = n;
      end
      if (s3 != 0 && n == s3 + 24) chk("t2_pre_lock", {31'd0, aligned}, 32'd0);
      if (s3 != 0 && n == s3 + 25) chk("t2_lock", {31'd0, aligned}, 32'd1);
    end
    chk("t2_slips", ns, 3);
    chk("t2_aligned", {31'd0, aligned}, 32'd1);
    chk("t2_slip_count", {28'd0, slip_count}, 32'd3);
    do_reset();
    for (int i = 0; i < 5000 && !bitslip; i++) send(10'h100);
    chk("t6a_slip_seen", {31'd0, bitslip}, 32'd1);
    rst = 1'b1;
    send(10'h100);
    check_reset("t6a");
    rst = 1'b0;
    do_reset();
    for (int i = 0; i < 5000 && !bitslip; i++) send(10'h100);
    chk("t6b_slip_seen", {31'd0, bitslip}, 32'd1);
    repeat (5) send(10'h100);
    chk("t6b_pre_count", {28'd0, slip_count}, 32'd1);
    rst = 1'b1;
    send(10'h100);
    check_reset("t6b");
    rst = 1'b0;
    prev_slip = 1'b0;
    s0 = slips;
    for (int i = 1; i <= 30; i++) begin
      send(10'h354);
      chk("t6b_relock", {31'd0, aligned}, {31'd0, i >= 9});
    end
    chk("t6b_no_slip", slips, s0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
